// File: rtl/switch_arbiter_if.sv
// rtl/switch_arbiter_if.sv - requester and switch-side beat signals of switch_arbiter
interface switch_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);

  // requester 0 beat channel
  logic                  req0_vld;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_rdy;

  // requester 1 beat channel
  logic                  req1_vld;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_rdy;

  // registered beat towards the switch
  logic                  sw_vld;
  logic [ADDR_WIDTH-1:0] sw_addr;
  logic [DATA_WIDTH-1:0] sw_data;

  // requesters and switch side
  modport master (
    output req0_vld, req0_addr, req0_data,
    input  req0_rdy,
    output req1_vld, req1_addr, req1_data,
    input  req1_rdy,
    input  sw_vld, sw_addr, sw_data
  );

  // arbiter side
  modport slave (
    input  req0_vld, req0_addr, req0_data,
    output req0_rdy,
    input  req1_vld, req1_addr, req1_data,
    output req1_rdy,
    output sw_vld, sw_addr, sw_data
  );

endinterface

// File: rtl/switch_arbiter.sv
// rtl/switch_arbiter.sv - round-robin burst-limited arbiter feeding the two-way address switch
module switch_arbiter #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] ADDR_DIV   = ADDR_WIDTH'(8'h3F),
  parameter int                    MAX_BURST  = 4,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  switch_arbiter_if.slave      bus,
  output logic                 busy,
  input  logic                 clr_stats,
  output logic [CNT_WIDTH-1:0] cnt_a,
  output logic [CNT_WIDTH-1:0] cnt_b
);

  // burst counter only needs to reach MAX_BURST-1; keep at least one bit for MAX_BURST=1
  localparam int                BURST_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t               state;
  logic                 last;
  logic [BURST_W-1:0]   burst_cnt;

  logic                  xfer0;
  logic                  xfer1;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_port_a;

  // ready follows the grant directly; reset masks it so no beat is taken while reset is held
  assign bus.req0_rdy = (state == GRANT0) && !rst;
  assign bus.req1_rdy = (state == GRANT1) && !rst;

  assign xfer0 = bus.req0_vld && bus.req0_rdy;
  assign xfer1 = bus.req1_vld && bus.req1_rdy;
  assign xfer  = xfer0 || xfer1;

  // at most one requester is ready, so the mux select is simply "requester 1 is transferring"
  assign sel_addr   = xfer1 ? bus.req1_addr : bus.req0_addr;
  assign sel_data   = xfer1 ? bus.req1_data : bus.req0_data;
  assign sel_port_a = (sel_addr <= ADDR_DIV);

  assign busy = (state != IDLE);

  // arbitration state: grant owner, round-robin pointer and beats taken in the current grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (bus.req0_vld && (!bus.req1_vld || last)) begin
            state <= GRANT0;
          end else if (bus.req1_vld) begin
            state <= GRANT1;
          end
        end

        GRANT0: begin
          if (bus.req0_vld) begin
            if (burst_cnt == BURST_LAST) begin
              // burst limit reached: hand over only if the other side is waiting
              burst_cnt <= '0;
              if (bus.req1_vld) begin
                state <= GRANT1;
                last  <= 1'b0;
              end
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end else begin
            // owner went quiet: switch straight over so the other side sees no idle cycle
            last      <= 1'b0;
            burst_cnt <= '0;
            state     <= bus.req1_vld ? GRANT1 : IDLE;
          end
        end

        GRANT1: begin
          if (bus.req1_vld) begin
            if (burst_cnt == BURST_LAST) begin
              burst_cnt <= '0;
              if (bus.req0_vld) begin
                state <= GRANT0;
                last  <= 1'b1;
              end
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end else begin
            last      <= 1'b1;
            burst_cnt <= '0;
            state     <= bus.req0_vld ? GRANT0 : IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  // one-cycle registered forward of the accepted beat; address/data hold when nothing moves
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sw_vld  <= 1'b0;
      bus.sw_addr <= '0;
      bus.sw_data <= '0;
    end else begin
      bus.sw_vld <= xfer;
      if (xfer) begin
        bus.sw_addr <= sel_addr;
        bus.sw_data <= sel_data;
      end
    end
  end

  // saturating per-destination beat counters; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (xfer) begin
      if (sel_port_a) begin
        if (cnt_a != '1) begin
          cnt_a <= cnt_a + 1'b1;
        end
      end else begin
        if (cnt_b != '1) begin
          cnt_b <= cnt_b + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_arbiter.sv
// tb/tb_switch_arbiter.sv - directed vector bench for switch_arbiter
module tb_switch_arbiter;

  localparam int NV = 35;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       clr_stats;
  logic [3:0] cnt_a;
  logic [3:0] cnt_b;

  switch_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

  switch_arbiter #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(16),
    .ADDR_DIV  (8'h3F),
    .MAX_BURST (4),
    .CNT_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .clr_stats(clr_stats),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b)
  );

  typedef struct {
    logic        rst;
    logic        v0;
    logic [7:0]  a0;
    logic        v1;
    logic [7:0]  a1;
    logic        clr;
    logic        r0;
    logic        r1;
    logic        bsy;
    logic        swv;
    logic [7:0]  swa;
    logic [15:0] swd;
    logic [3:0]  ca;
    logic [3:0]  cb;
  } vec_t;

  vec_t vecs [NV];
  int   errors;
  int   checks;
  int   acc;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int d0(input int a);
    return 32'hA500 | a;
  endfunction

  function automatic int d1(input int a);
    return 32'h5A00 | a;
  endfunction

  function automatic vec_t mk(input int rst_i, input int v0, input int a0, input int v1,
                              input int a1, input int clr, input int r0, input int r1,
                              input int bsy, input int swv, input int swa, input int swd,
                              input int ca, input int cb);
    vec_t r;
    r.rst = rst_i[0];
    r.v0  = v0[0];
    r.a0  = 8'(a0);
    r.v1  = v1[0];
    r.a1  = 8'(a1);
    r.clr = clr[0];
    r.r0  = r0[0];
    r.r1  = r1[0];
    r.bsy = bsy[0];
    r.swv = swv[0];
    r.swa = 8'(swa);
    r.swd = 16'(swd);
    r.ca  = 4'(ca);
    r.cb  = 4'(cb);
    return r;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v0, input logic [7:0] a0, input logic v1,
                       input logic [7:0] a1, input logic clr);
    rst           = r;
    bus.req0_vld  = v0;
    bus.req0_addr = a0;
    bus.req0_data = 16'(d0(int'(a0)));
    bus.req1_vld  = v1;
    bus.req1_addr = a1;
    bus.req1_data = 16'(d1(int'(a1)));
    clr_stats     = clr;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    //             rst v0 a0     v1 a1     clr  r0 r1 bsy swv swa    swd             ca  cb
    // reset
    vecs[0]  = mk(1,  0, 'h00,  0, 'h00,  0,   0, 0, 0,  0,  'h00,  0,              0,  0);
    vecs[1]  = mk(1,  0, 'h00,  0, 'h00,  0,   0, 0, 0,  0,  'h00,  0,              0,  0);
    // single requester, six beats, one idle cycle then back to back
    vecs[2]  = mk(0,  1, 'h10,  0, 'h00,  0,   0, 0, 0,  0,  'h00,  0,              0,  0);
    vecs[3]  = mk(0,  1, 'h10,  0, 'h00,  0,   1, 0, 1,  0,  'h00,  0,              0,  0);
    vecs[4]  = mk(0,  1, 'h11,  0, 'h00,  0,   1, 0, 1,  1,  'h10,  d0('h10),       1,  0);
    vecs[5]  = mk(0,  1, 'h12,  0, 'h00,  0,   1, 0, 1,  1,  'h11,  d0('h11),       2,  0);
    vecs[6]  = mk(0,  1, 'h13,  0, 'h00,  0,   1, 0, 1,  1,  'h12,  d0('h12),       3,  0);
    vecs[7]  = mk(0,  1, 'h14,  0, 'h00,  0,   1, 0, 1,  1,  'h13,  d0('h13),       4,  0);
    vecs[8]  = mk(0,  1, 'h15,  0, 'h00,  0,   1, 0, 1,  1,  'h14,  d0('h14),       5,  0);
    vecs[9]  = mk(0,  0, 'h00,  0, 'h00,  0,   1, 0, 1,  1,  'h15,  d0('h15),       6,  0);
    vecs[10] = mk(0,  0, 'h00,  0, 'h00,  0,   0, 0, 0,  0,  'h15,  d0('h15),       6,  0);
    // contention: last=0 so requester 1 wins, 4-beat bursts, no bubble at the switch-over
    vecs[11] = mk(0,  1, 'h20,  1, 'h80,  0,   0, 0, 0,  0,  'h15,  d0('h15),       6,  0);
    vecs[12] = mk(0,  1, 'h20,  1, 'h80,  0,   0, 1, 1,  0,  'h15,  d0('h15),       6,  0);
    vecs[13] = mk(0,  1, 'h20,  1, 'h81,  0,   0, 1, 1,  1,  'h80,  d1('h80),       6,  1);
    vecs[14] = mk(0,  1, 'h20,  1, 'h82,  0,   0, 1, 1,  1,  'h81,  d1('h81),       6,  2);
    vecs[15] = mk(0,  1, 'h20,  1, 'h83,  0,   0, 1, 1,  1,  'h82,  d1('h82),       6,  3);
    vecs[16] = mk(0,  1, 'h20,  1, 'h84,  0,   1, 0, 1,  1,  'h83,  d1('h83),       6,  4);
    vecs[17] = mk(0,  1, 'h21,  1, 'h84,  0,   1, 0, 1,  1,  'h20,  d0('h20),       7,  4);
    vecs[18] = mk(0,  1, 'h22,  1, 'h84,  0,   1, 0, 1,  1,  'h21,  d0('h21),       8,  4);
    vecs[19] = mk(0,  1, 'h23,  1, 'h84,  0,   1, 0, 1,  1,  'h22,  d0('h22),       9,  4);
    vecs[20] = mk(0,  1, 'h24,  1, 'h84,  0,   0, 1, 1,  1,  'h23,  d0('h23),       10, 4);
    // owner drops vld while the other waits: direct hand-over without IDLE
    vecs[21] = mk(0,  1, 'h24,  0, 'h00,  0,   0, 1, 1,  1,  'h84,  d1('h84),       10, 5);
    vecs[22] = mk(0,  1, 'h24,  0, 'h00,  0,   1, 0, 1,  0,  'h84,  d1('h84),       10, 5);
    // routing split at 3F / 40
    vecs[23] = mk(0,  1, 'h3F,  0, 'h00,  0,   1, 0, 1,  1,  'h24,  d0('h24),       11, 5);
    vecs[24] = mk(0,  1, 'h40,  0, 'h00,  0,   1, 0, 1,  1,  'h3F,  d0('h3F),       12, 5);
    vecs[25] = mk(0,  0, 'h00,  0, 'h00,  0,   1, 0, 1,  1,  'h40,  d0('h40),       12, 6);
    vecs[26] = mk(0,  0, 'h00,  0, 'h00,  0,   0, 0, 0,  0,  'h40,  d0('h40),       12, 6);
    // reset during the second beat of a grant
    vecs[27] = mk(0,  0, 'h00,  1, 'h90,  0,   0, 0, 0,  0,  'h40,  d0('h40),       12, 6);
    vecs[28] = mk(0,  1, 'h30,  1, 'h90,  0,   0, 1, 1,  0,  'h40,  d0('h40),       12, 6);
    vecs[29] = mk(1,  1, 'h30,  1, 'h91,  0,   0, 0, 1,  1,  'h90,  d1('h90),       12, 7);
    vecs[30] = mk(0,  1, 'h30,  1, 'h91,  0,   0, 0, 0,  0,  'h00,  0,              0,  0);
    vecs[31] = mk(0,  1, 'h30,  1, 'h91,  0,   1, 0, 1,  0,  'h00,  0,              0,  0);
    vecs[32] = mk(0,  0, 'h00,  1, 'h91,  0,   1, 0, 1,  1,  'h30,  d0('h30),       1,  0);
    vecs[33] = mk(0,  0, 'h00,  0, 'h00,  0,   0, 1, 1,  0,  'h30,  d0('h30),       1,  0);
    vecs[34] = mk(0,  0, 'h00,  0, 'h00,  0,   0, 0, 0,  0,  'h30,  d0('h30),       1,  0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].v0, vecs[i].a0, vecs[i].v1, vecs[i].a1, vecs[i].clr);
      #1;
      check("req0_rdy", i, 32'(bus.req0_rdy), 32'(vecs[i].r0));
      check("req1_rdy", i, 32'(bus.req1_rdy), 32'(vecs[i].r1));
      check("busy",     i, 32'(busy),         32'(vecs[i].bsy));
      check("sw_vld",   i, 32'(bus.sw_vld),   32'(vecs[i].swv));
      check("sw_addr",  i, 32'(bus.sw_addr),  32'(vecs[i].swa));
      check("sw_data",  i, 32'(bus.sw_data),  32'(vecs[i].swd));
      check("cnt_a",    i, 32'(cnt_a),        32'(vecs[i].ca));
      check("cnt_b",    i, 32'(cnt_b),        32'(vecs[i].cb));
    end

    // saturation: 20 beats to port B through a 4-bit counter
    acc = 0;
    cyc = 0;
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'hC0, 1'b0);
    while (acc < 20 && cyc < 100) begin
      #1;
      if (bus.req1_rdy) acc++;
      cyc++;
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'hC0, 1'b0);
    #1;
    check("sat_accepted", 100, 32'(acc),        32'd20);
    check("sat_cycles",   100, 32'(cyc),        32'd21);
    check("sat_cnt_b",    100, 32'(cnt_b),      32'hF);
    check("sat_cnt_a",    100, 32'(cnt_a),      32'd1);
    check("sat_sw_vld",   100, 32'(bus.sw_vld), 32'd1);
    check("sat_sw_addr",  100, 32'(bus.sw_addr), 32'hC0);

    // clear concurrent with a transfer: clear wins
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'hC1, 1'b0);
    #1;
    check("clr_idle_rdy1", 101, 32'(bus.req1_rdy), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'hC1, 1'b1);
    #1;
    check("clr_grant_rdy1", 102, 32'(bus.req1_rdy), 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #1;
    check("clr_cnt_b",   103, 32'(cnt_b),       32'd0);
    check("clr_cnt_a",   103, 32'(cnt_a),       32'd0);
    check("clr_sw_vld",  103, 32'(bus.sw_vld),  32'd1);
    check("clr_sw_addr", 103, 32'(bus.sw_addr), 32'hC1);
    check("clr_sw_data", 103, 32'(bus.sw_data), 32'(d1('hC1)));
    @(negedge clk);
    #1;
    check("end_busy",   104, 32'(busy),       32'd0);
    check("end_sw_vld", 104, 32'(bus.sw_vld), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
